// File: rtl/startpage_fade_mixer.sv
// startpage_fade_mixer: palette lookup and alpha blend of the start page over the game layer, with frame-synchronous fade FSM
module startpage_fade_mixer #(
  parameter int FADE_STEP_FRAMES = 2,
  parameter int ALPHA_MAX        = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       startpage_exist,
  input  logic       frame_start,
  input  logic       blank,
  input  logic [7:0] game_r,
  input  logic [7:0] game_g,
  input  logic [7:0] game_b,
  input  logic [3:0] startpage_data,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue,
  output logic       fade_busy,
  output logic       startpage_visible
);
  typedef enum logic [1:0] {HIDDEN, FADE_IN, SHOWN, FADE_OUT} state_t;
  localparam int CW = FADE_STEP_FRAMES > 1 ? $clog2(FADE_STEP_FRAMES) : 1;
  localparam logic [4:0] AMAX = 5'(ALPHA_MAX);
  localparam logic [CW-1:0] LAST = CW'(FADE_STEP_FRAMES - 1);
  localparam logic [23:0] PALETTE [16] = '{
    24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
    24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF,
    24'h808080, 24'hC0C0C0, 24'h800000, 24'h008000,
    24'h000080, 24'hFFA500, 24'h402010, 24'h202040
  };
  state_t          r_state, w_state;
  logic [4:0]      r_alpha, w_alpha;
  logic [CW-1:0]   r_step, w_step;
  logic            w_last;
  logic            r_blank;
  logic [7:0]      r_gr, r_gg, r_gb;
  logic [23:0]     w_pal;
  function automatic logic [7:0] mix(input logic [7:0] sp, input logic [7:0] g, input logic [4:0] a);
    logic [11:0] s;
    s = 12'(sp) * 12'(a) + 12'(g) * 12'(AMAX - a);
    return s[11:4];
  endfunction
  always_comb begin
    w_state = r_state;
    w_alpha = r_alpha;
    w_step  = r_step;
    w_last  = r_step == LAST;
    if (frame_start) begin
      case (r_state)
        HIDDEN: begin
          w_alpha = '0;
          if (startpage_exist) begin
            w_state = FADE_IN;
            w_step  = '0;
          end
        end
        FADE_IN: begin
          if (!startpage_exist) begin
            w_state = FADE_OUT;
            w_step  = '0;
          end else if (w_last) begin
            w_step  = '0;
            w_alpha = r_alpha >= AMAX ? AMAX : r_alpha + 5'd1;
            w_state = w_alpha == AMAX ? SHOWN : FADE_IN;
          end else w_step = r_step + CW'(1);
        end
        SHOWN: begin
          w_alpha = AMAX;
          if (!startpage_exist) begin
            w_state = FADE_OUT;
            w_step  = '0;
          end
        end
        default: begin
          if (startpage_exist) begin
            w_state = FADE_IN;
            w_step  = '0;
          end else if (w_last) begin
            w_step  = '0;
            w_alpha = r_alpha == 5'd0 ? 5'd0 : r_alpha - 5'd1;
            w_state = w_alpha == 5'd0 ? HIDDEN : FADE_OUT;
          end else w_step = r_step + CW'(1);
        end
      endcase
    end
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state           <= HIDDEN;
      r_alpha           <= '0;
      r_step            <= '0;
      fade_busy         <= 1'b0;
      startpage_visible <= 1'b0;
    end else begin
      r_state           <= w_state;
      r_alpha           <= w_alpha;
      r_step            <= w_step;
      fade_busy         <= w_state == FADE_IN || w_state == FADE_OUT;
      startpage_visible <= w_alpha != 5'd0;
    end
  end
  // stage A lines the game layer up with the one-cycle-late palette index
  assign w_pal = PALETTE[startpage_data];
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_blank <= 1'b0;
      r_gr    <= '0;
      r_gg    <= '0;
      r_gb    <= '0;
      Red     <= '0;
      Green   <= '0;
      Blue    <= '0;
    end else begin
      r_blank <= blank;
      r_gr    <= game_r;
      r_gg    <= game_g;
      r_gb    <= game_b;
      Red     <= r_blank ? mix(w_pal[23:16], r_gr, r_alpha) : 8'd0;
      Green   <= r_blank ? mix(w_pal[15:8], r_gg, r_alpha) : 8'd0;
      Blue    <= r_blank ? mix(w_pal[7:0], r_gb, r_alpha) : 8'd0;
    end
  end
endmodule

// File: tb/tb_startpage_fade_mixer.sv
// tb_startpage_fade_mixer: directed checks of reset, passthrough, fade timing, blend, palette, blanking and reversal
module tb_startpage_fade_mixer;
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       startpage_exist = 1'b0;
  logic       frame_start = 1'b0;
  logic       blank = 1'b0;
  logic [7:0] game_r = '0, game_g = '0, game_b = '0;
  logic [3:0] startpage_data = '0;
  logic [7:0] Red, Green, Blue;
  logic       fade_busy, startpage_visible;
  int errors = 0;
  int checks = 0;

  startpage_fade_mixer #(.FADE_STEP_FRAMES(2), .ALPHA_MAX(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .startpage_exist(startpage_exist), .frame_start(frame_start),
    .blank(blank), .game_r(game_r), .game_g(game_g), .game_b(game_b),
    .startpage_data(startpage_data), .Red(Red), .Green(Green), .Blue(Blue),
    .fade_busy(fade_busy), .startpage_visible(startpage_visible)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      {game_r, game_g, game_b} = 24'($urandom);
      startpage_data = 4'($urandom);
      blank = 1'($urandom);
      frame_start = 1'($urandom);
      startpage_exist = 1'($urandom);
      tick();
      checks++;
      if ({Red, Green, Blue, fade_busy, startpage_visible} !== 26'd0) begin
        errors++;
        $display("FAIL reset cyc%0d: rgb=%h busy=%b vis=%b, want 0", i, {Red, Green, Blue}, fade_busy, startpage_visible);
      end
    end
    Reset_n = 1'b1;
    frame_start = 1'b0;
    startpage_exist = 1'b0;
    blank = 1'b0;
  endtask

  task automatic test_passthrough;
    {game_r, game_g, game_b} = 24'h123456;
    startpage_data = 4'd2;
    blank = 1'b1;
    tick();
    checks++;
    if ({Red, Green, Blue} !== 24'h000000) begin
      errors++;
      $display("FAIL pass_latency1: rgb=%h, want 000000", {Red, Green, Blue});
    end
    tick();
    checks++;
    if ({Red, Green, Blue} !== 24'h123456) begin
      errors++;
      $display("FAIL pass_latency2: rgb=%h, want 123456", {Red, Green, Blue});
    end
    for (int f = 0; f < 5; f++) begin
      startpage_exist = 1'b1;
      tick();
      startpage_exist = 1'b0;
      pulse();
      checks++;
      if ({Red, Green, Blue, fade_busy, startpage_visible} !== {24'h123456, 2'b00}) begin
        errors++;
        $display("FAIL pass_frame%0d: rgb=%h busy=%b vis=%b, want 123456 0 0", f, {Red, Green, Blue}, fade_busy, startpage_visible);
      end
    end
  endtask

  task automatic test_fade_in(input int from, input int to);
    logic [7:0] e;
    for (int p = from; p <= to; p++) begin
      pulse();
      e = 8'((255 * (p / 2)) / 16);
      checks++;
      if ({Red, Green, Blue} !== {e, e, e} || fade_busy !== (p < 32) || startpage_visible !== (p >= 2)) begin
        errors++;
        $display("FAIL fade_in_p%0d: rgb=%h busy=%b vis=%b, want %h%h%h %b %b", p, {Red, Green, Blue},
                 fade_busy, startpage_visible, e, e, e, p < 32, p >= 2);
      end
    end
  endtask

  task automatic test_blend;
    startpage_data = 4'd1;
    {game_r, game_g, game_b} = 24'h000000;
    repeat (2) tick();
    checks++;
    if ({Red, Green, Blue} !== 24'h7F7F7F) begin
      errors++;
      $display("FAIL blend_white_over_black: rgb=%h, want 7F7F7F", {Red, Green, Blue});
    end
    startpage_data = 4'd0;
    {game_r, game_g, game_b} = 24'hFFFFFF;
    repeat (2) tick();
    checks++;
    if ({Red, Green, Blue} !== 24'h7F7F7F) begin
      errors++;
      $display("FAIL blend_black_over_white: rgb=%h, want 7F7F7F", {Red, Green, Blue});
    end
    startpage_data = 4'd1;
    {game_r, game_g, game_b} = 24'h000000;
    repeat (2) tick();
  endtask

  task automatic test_palette;
    logic [23:0] exp_tab [5];
    exp_tab = '{24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF};
    {game_r, game_g, game_b} = 24'h5A5A5A;
    for (int i = 0; i < 5; i++) begin
      startpage_data = 4'(i);
      repeat (2) tick();
      checks++;
      if ({Red, Green, Blue} !== exp_tab[i]) begin
        errors++;
        $display("FAIL palette_%0d: rgb=%h, want %h", i, {Red, Green, Blue}, exp_tab[i]);
      end
    end
    startpage_data = 4'd1;
    {game_r, game_g, game_b} = 24'h000000;
    repeat (2) tick();
  endtask

  task automatic test_blanking;
    logic [23:0] seen [3];
    blank = 1'b0;
    tick();
    blank = 1'b1;
    seen[0] = {Red, Green, Blue};
    tick();
    seen[1] = {Red, Green, Blue};
    tick();
    seen[2] = {Red, Green, Blue};
    checks++;
    if (seen[0] !== 24'hFFFFFF || seen[1] !== 24'h000000 || seen[2] !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL blanking: rgb=%h,%h,%h, want FFFFFF,000000,FFFFFF", seen[0], seen[1], seen[2]);
    end
  endtask

  task automatic test_reset_mid_fade;
    startpage_exist = 1'b0;
    pulse();
    checks++;
    if (fade_busy !== 1'b1 || {Red, Green, Blue} !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL fade_out_start: busy=%b rgb=%h, want 1 FFFFFF", fade_busy, {Red, Green, Blue});
    end
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    checks++;
    if ({Red, Green, Blue, fade_busy, startpage_visible} !== 26'd0) begin
      errors++;
      $display("FAIL reset_mid_fade: rgb=%h busy=%b vis=%b, want 0", {Red, Green, Blue}, fade_busy, startpage_visible);
    end
  endtask

  task automatic test_reversal;
    logic [7:0] e;
    int a;
    blank = 1'b1;
    startpage_exist = 1'b1;
    for (int p = 0; p <= 10; p++) pulse();
    checks++;
    if ({Red, Green, Blue} !== 24'h4F4F4F || fade_busy !== 1'b1) begin
      errors++;
      $display("FAIL rev_alpha5: rgb=%h busy=%b, want 4F4F4F 1", {Red, Green, Blue}, fade_busy);
    end
    startpage_exist = 1'b0;
    pulse();
    checks++;
    if ({Red, Green, Blue} !== 24'h4F4F4F || fade_busy !== 1'b1 || startpage_visible !== 1'b1) begin
      errors++;
      $display("FAIL rev_turn: rgb=%h busy=%b vis=%b, want 4F4F4F 1 1", {Red, Green, Blue}, fade_busy, startpage_visible);
    end
    for (int k = 1; k <= 10; k++) begin
      pulse();
      a = 5 - k / 2;
      e = 8'((255 * a) / 16);
      checks++;
      if ({Red, Green, Blue} !== {e, e, e} || fade_busy !== (k < 10) || startpage_visible !== (a != 0)) begin
        errors++;
        $display("FAIL rev_out_k%0d: rgb=%h busy=%b vis=%b, want %h%h%h %b %b", k, {Red, Green, Blue},
                 fade_busy, startpage_visible, e, e, e, k < 10, a != 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    startpage_data = 4'd1;
    {game_r, game_g, game_b} = 24'h000000;
    startpage_exist = 1'b1;
    test_fade_in(0, 16);
    test_blend();
    test_fade_in(17, 32);
    test_palette();
    test_blanking();
    test_reset_mid_fade();
    test_reversal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
